// File: rtl/cpu_pkg.sv
// Shared types and defaults for the fetch front end of the pipelined core.
package cpu_pkg;

   typedef logic [31:0] word_t;

   // One prefetch FIFO entry: the fetched instruction word.
   typedef struct packed {
      word_t instr;
   } fetch_entry_t;

   localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam word_t NOP_INSTR_DEFAULT = 32'hE280_0000;   // ADD r0,r0,#0

   // Instruction addresses are word aligned; low two bits are always zero.
   function automatic word_t align_pc(input word_t pc);
      return pc & ~word_t'(32'h3);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic  ImemReqValid;
   logic  ImemReqReady;
   word_t ImemAddr;
   logic  ImemRspValid;
   word_t ImemRspData;

   modport master (
      output ImemReqValid, ImemAddr,
      input  ImemReqReady, ImemRspValid, ImemRspData
   );

   modport slave (
      input  ImemReqValid, ImemAddr,
      output ImemReqReady, ImemRspValid, ImemRspData
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO; clear wins over push and pop.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     clear,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_en, pop_en;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // A push into a full FIFO is only accepted when a pop frees the slot.
   assign push_en = push & ~clear & (~full | pop);
   assign pop_en  = pop & ~clear & ~empty;

   // Pointer and occupancy next state.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_en) - CW'(pop_en);
      end
   end

   // Pointer/count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only read while count says they are valid.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC generation, imem requests, prefetch, redirect.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter word_t       RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH     = 2,
   parameter word_t       NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          StallF,
   input  logic          StallD,
   input  logic          FlushD,
   input  logic          BranchTakenE,
   input  word_t         ALUResultE,
   input  logic          PCSrcW,
   input  word_t         ResultW,
   fetch_stage_if.master imem,
   output word_t         InstrD,
   output word_t         PCPlus8D,
   output logic          ValidD
);
   localparam int unsigned CW        = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);
   localparam word_t       PC_RST    = align_pc(RESET_PC);

   word_t         pcf_q, pcf_d;
   word_t         head_pc_q, head_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   word_t         ifid_instr_q, ifid_instr_d;
   word_t         ifid_pc8_q, ifid_pc8_d;
   logic          ifid_valid_q, ifid_valid_d;

   logic          redirect, req_ok, req_fire, rsp_valid, rsp_keep;
   logic          advance, bypass, fifo_push, fifo_pop;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;
   word_t         target;
   fetch_entry_t  push_entry, head_entry;

   // Redirect and issue control: never issue more than the FIFO can absorb.
   assign redirect  = BranchTakenE | PCSrcW;
   assign target    = align_pc(BranchTakenE ? ALUResultE : ResultW);
   assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign req_ok    = ~StallF & ~redirect & (occupancy < DEPTH_OCC);
   assign req_fire  = req_ok & imem.ImemReqReady;
   assign rsp_valid = imem.ImemRspValid;
   assign rsp_keep  = rsp_valid & (drop_cnt_q == '0);

   // Decode advance: pop the FIFO head, or bypass a response when it is empty.
   assign advance    = ~redirect & ~StallD & ~FlushD;
   assign fifo_pop   = advance & ~fifo_empty;
   assign bypass     = advance & fifo_empty & rsp_keep;
   assign fifo_push  = ~redirect & rsp_keep & ~bypass;
   assign push_entry = '{instr: imem.ImemRspData};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .clear     (redirect),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next state for PC, head PC, in-flight tracking and the IF/ID register.
   always_comb begin
      pcf_d         = pcf_q;
      head_pc_d     = head_pc_q;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_valid);
      drop_cnt_d    = drop_cnt_q;
      ifid_instr_d  = ifid_instr_q;
      ifid_pc8_d    = ifid_pc8_q;
      ifid_valid_d  = ifid_valid_q;
      if (redirect) begin
         pcf_d        = target;
         head_pc_d    = target;
         drop_cnt_d   = outstanding_q - CW'(rsp_valid);
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
      end else begin
         if (req_fire)              pcf_d      = pcf_q + 32'd4;
         if (rsp_valid && !rsp_keep) drop_cnt_d = drop_cnt_q - CW'(1);
         if (fifo_pop || bypass) begin
            ifid_instr_d = fifo_pop ? head_entry.instr : imem.ImemRspData;
            ifid_pc8_d   = head_pc_q + 32'd8;
            ifid_valid_d = 1'b1;
            head_pc_d    = head_pc_q + 32'd4;
         end else if (!StallD) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_q         <= PC_RST;
         head_pc_q     <= PC_RST;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         ifid_instr_q  <= NOP_INSTR;
         ifid_pc8_q    <= PC_RST + 32'd8;
         ifid_valid_q  <= 1'b0;
      end else begin
         pcf_q         <= pcf_d;
         head_pc_q     <= head_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         ifid_instr_q  <= ifid_instr_d;
         ifid_pc8_q    <= ifid_pc8_d;
         ifid_valid_q  <= ifid_valid_d;
      end
   end

   assign imem.ImemReqValid = reset & req_ok;
   assign imem.ImemAddr     = pcf_q;
   assign InstrD            = ifid_instr_q;
   assign PCPlus8D          = ifid_pc8_q;
   assign ValidD            = ifid_valid_q;

   // Protocol and bookkeeping invariants.
   assert property (@(posedge clk) disable iff (!reset)
      !(fifo_push && fifo_full && !fifo_pop));
   assert property (@(posedge clk) disable iff (!reset)
      drop_cnt_q <= outstanding_q);
   assert property (@(posedge clk) disable iff (!reset)
      (imem.ImemReqValid && !imem.ImemReqReady) |=> $stable(imem.ImemAddr));

endmodule
